shift_rows_pipe: RTL
====================

Name: shift_rows_pipe

Overview:
- Parametrised, pipelined Rijndael ShiftRows / InvShiftRows layer for block widths Nb = 4, 6 or 8 columns (128/192/256-bit state).
- The direction is chosen per transaction.
- Data moves through STAGES registered slots with a valid/ready handshake, a sideband tag and a synchronous flush.
- Sits between SubBytes and MixColumns in the iterative round datapath. Also used by Rijndael-256 experiments.

Parameters:
- NB, 4, state columns; legal values 4, 6, 8; any other value is an elaboration error.
- STAGES, 1, number of pipeline register slots (>=1); unstalled latency in cycles.
- TAG_W, 4, width of the sideband tag carried alongside each state.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of all slots
- in_valid  input  1  upstream state valid
- in_ready  output  1  slot 0 can accept this cycle
- in_data  input  32*NB  state; byte k=4c+r at bits [32*NB-1-8k -: 8] (byte 0 = MSB)
- in_inverse  input  1  0=ShiftRows, 1=InvShiftRows
- in_tag  input  TAG_W  sideband, passed unchanged
- out_valid  output  1  last slot holds a result
- out_ready  input  1  downstream accepts
- out_data  output  32*NB  shifted state
- out_tag  output  TAG_W  tag of the out_data transaction
- occupancy  output  $clog2(STAGES+1)  number of valid slots

Behaviour:
- Shift offsets s_r for rows r=0..3:
  - 0,1,2,3 for NB=4 and NB=6.
  - 0,1,3,4 for NB=8.
- Forward: out(r,c) = in(r,(c+s_r) mod NB).
- Inverse: out(r,c) = in(r,(c-s_r+NB) mod NB).
- Permutation is combinational on in_data, using in_inverse. The permuted result is what slot 0 captures.
- Slots 1..STAGES-1 are pure pass-through.
- Transfer in: in_valid && in_ready at a rising edge.
- Transfer out: out_valid && out_ready at a rising edge.
- Each slot holds valid, data and tag.
- Slot i advances when slot i+1 is empty or slot i+1 advances (last slot: when out_ready).
- in_ready = !flush && (slot0 empty || slot0 advances).
- in_ready may depend combinationally on out_ready. No other combinational in->out paths.
- Latency: with out_ready held high, a state accepted at edge n appears with out_valid high after edge n+STAGES-1 (STAGES=1: visible the cycle after acceptance).
- Throughput: one transaction per cycle when unstalled.
- Stall: out_valid && !out_ready freezes the last slot. Data and tag stay stable until accepted. Upstream slots fill bubbles and then backpressure.
- No loss or duplication is permitted under any out_ready pattern.
- occupancy: registered count of valid slots.
  - +1 on transfer in, -1 on transfer out, unchanged when both occur.
  - Never exceeds STAGES.
- flush: at the next edge all valid bits and occupancy clear. The in_valid of that cycle is ignored (in_ready is 0).
- flush and out transfer in the same cycle: out_valid is still presented that cycle, but the handshake does not count; downstream must ignore it.
- reset (async, any time, including mid-stall):
  - All valid bits 0, data 0, tag 0, occupancy 0.
  - out_valid=0, out_data=0, out_tag=0.
  - in_ready=0 while reset is high; in_ready=1 on the first cycle after release.
- Mode is captured per transaction. Back-to-back forward/inverse transactions are processed independently.

Test Plan:
- NB=4, STAGES=1, forward, in_data=d42711aee0bf98f1b8b45de51e415230, tag=3 -> out_data=d4bf5d30e0b452aeb84111f11e2798e5, out_tag=3, one cycle after accept.
- NB=4, inverse, in_data=d4bf5d30e0b452aeb84111f11e2798e5 -> out_data=d42711aee0bf98f1b8b45de51e415230. Alternating fwd/inv every cycle at full rate yields correct per-transaction results.
- NB=8, forward, in_data bytes 00,01,...,1F -> out_data begins 00 05 0E 13 04 09 12 17. Inverse of that result restores 00..1F.
- STAGES=3, 10 random back-to-back states:
  - out_ready high -> first out_valid 3 edges after the first accept, 10 consecutive results, occupancy peaks at 3.
  - Random out_ready -> same 10 results in order, out_data stable while stalled.
- STAGES=3, fill with out_ready=0 -> in_ready drops after 3 accepts, occupancy=3. Then assert flush one cycle -> occupancy=0, out_valid=0, in_ready=1 the next cycle.
- Assert reset asynchronously mid-stall with 2 slots full -> out_valid/out_data/out_tag/occupancy go 0 immediately. After release, a new transaction completes correctly.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: pipelined Rijndael ShiftRows/InvShiftRows for Nb=4/6/8 with valid/ready, tag and flush.
// Slot 0 captures the permuted state; later slots pass it through unchanged.
module shift_rows_pipe #(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [32*NB-1:0]                 in_data,
  input  logic                             in_inverse,
  input  logic [TAG_W-1:0]                 in_tag,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [32*NB-1:0]                 out_data,
  output logic [TAG_W-1:0]                 out_tag,
  output logic [$clog2(STAGES+1)-1:0]      occupancy
);
  localparam int W  = 32*NB;
  localparam int OW = $clog2(STAGES+1);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  logic [W-1:0]       w_perm;
  logic [STAGES-1:0]  r_v;
  logic [W-1:0]       r_d [STAGES];
  logic [TAG_W-1:0]   r_t [STAGES];
  logic [STAGES:0]    w_free;
  logic               w_in_xfer;
  logic               w_out_xfer;

  // Rijndael-256 uses offsets 0,1,3,4; the narrower blocks use 0,1,2,3.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int S = (NB == 8 && r > 1) ? r + 1 : r;
      localparam int F = (c + S) % NB;
      localparam int I = (c - S + NB) % NB;
      assign w_perm[W-1-8*(4*c+r) -: 8] = in_inverse ? in_data[W-1-8*(4*I+r) -: 8]
                                                     : in_data[W-1-8*(4*F+r) -: 8];
    end
  end

  // A slot may load when it is empty or its content moves on this edge.
  always_comb begin
    w_free[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) w_free[i] = !r_v[i] || w_free[i+1];
  end

  assign in_ready   = !reset && !flush && w_free[0];
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready && !flush;
  assign out_valid  = r_v[STAGES-1];
  assign out_data   = r_d[STAGES-1];
  assign out_tag    = r_t[STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_v       <= '0;
      occupancy <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_d[i] <= '0;
        r_t[i] <= '0;
      end
    end else begin
      if (w_free[0]) begin
        r_v[0] <= w_in_xfer;
        r_d[0] <= w_perm;
        r_t[0] <= in_tag;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (w_free[i]) begin
          r_v[i] <= r_v[i-1];
          r_d[i] <= r_d[i-1];
          r_t[i] <= r_t[i-1];
        end
      end
      if (flush) r_v <= '0;
      occupancy <= flush ? '0 : occupancy + OW'(w_in_xfer) - OW'(w_out_xfer);
    end
  end
endmodule
